// File: rtl/interboard_tx_scheduler.sv
// interboard_tx_scheduler: two-producer FIFO arbiter feeding the interboard ctrl_* command port.
// Define TX_SCHED_COALESCE_EN so a push to a full B FIFO overwrites its newest entry.
module interboard_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 22,
    parameter bit OVERWRITE = 1'b0
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr, rd;
    logic [AW:0] cnt;
    logic do_pop, do_push;
    assign full = cnt == (AW+1)'(DEPTH);
    assign empty = cnt == '0;
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout = mem[rd];
    always_ff @(posedge clk) begin
        if (clr) begin
            wr <= '0;
            rd <= '0;
            cnt <= '0;
        end else begin
            if (do_push) begin
                mem[wr] <= din;
                wr <= wr + AW'(1);
            end else if (push && OVERWRITE)
                mem[wr - AW'(1)] <= din;
            if (do_pop)
                rd <= rd + AW'(1);
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

module interboard_tx_scheduler #(
    parameter int DEPTH = 4,
    parameter int A_STREAK_MAX = 3,
    parameter int GAP_CYCLES = 8,
    parameter int BUSY_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        transmit,
    input  logic        interboard_rst,
    input  logic        tx_busy,
    input  logic        a_en,
    input  logic [21:0] a_msg,
    input  logic        b_en,
    input  logic [21:0] b_msg,
    output logic        a_full,
    output logic        b_full,
    output logic        b_overflow,
    output logic        timeout_err,
    output logic        ctrl_en,
    output logic        ctrl_move_dir,
    output logic [4:0]  ctrl_block_x,
    output logic [2:0]  ctrl_block_y,
    output logic [3:0]  ctrl_msg_type,
    output logic [5:0]  ctrl_card,
    output logic [2:0]  ctrl_sel_len
);
`ifdef TX_SCHED_COALESCE_EN
    localparam bit COALESCE = 1'b1;
`else
    localparam bit COALESCE = 1'b0;
`endif
    localparam logic [2:0] S_IDLE = 3'd0, S_ISSUE = 3'd1, S_RISE = 3'd2, S_FALL = 3'd3, S_GAP = 3'd4;
    localparam int SW = $clog2(A_STREAK_MAX + 1);
    localparam int CW = $clog2((BUSY_TIMEOUT > GAP_CYCLES ? BUSY_TIMEOUT : GAP_CYCLES) + 1);
    logic clr, a_empty, b_empty, grant_a, grant_b, grant;
    logic [21:0] a_head, b_head, cur;
    logic [2:0] state;
    logic [SW-1:0] streak;
    logic [CW-1:0] cnt;
    assign clr = rst || interboard_rst;
    assign grant_a = state == S_IDLE && transmit && !a_empty && (b_empty || streak < SW'(A_STREAK_MAX));
    assign grant_b = state == S_IDLE && transmit && !b_empty && !grant_a;
    assign grant = grant_a || grant_b;
    assign ctrl_en = state == S_ISSUE;
    assign {ctrl_move_dir, ctrl_block_x, ctrl_block_y, ctrl_msg_type, ctrl_card, ctrl_sel_len} = cur;
    interboard_tx_fifo #(.DEPTH(DEPTH), .W(22), .OVERWRITE(1'b0)) u_fifo_a (
        .clk(clk), .clr(clr), .push(a_en), .pop(grant_a), .din(a_msg),
        .dout(a_head), .full(a_full), .empty(a_empty)
    );
    interboard_tx_fifo #(.DEPTH(DEPTH), .W(22), .OVERWRITE(COALESCE)) u_fifo_b (
        .clk(clk), .clr(clr), .push(b_en), .pop(grant_b), .din(b_msg),
        .dout(b_head), .full(b_full), .empty(b_empty)
    );
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= S_IDLE;
            streak <= '0;
            cnt <= '0;
            cur <= '0;
            timeout_err <= 1'b0;
            b_overflow <= 1'b0;
        end else begin
            b_overflow <= b_en && b_full && !grant_b;
            if (grant) begin
                cur <= grant_a ? a_head : b_head;
                streak <= grant_b ? '0 : streak + SW'(streak < SW'(A_STREAK_MAX));
            end
            // losing the link discards whatever is in flight; queued entries stay
            if (!transmit)
                state <= S_IDLE;
            else
                case (state)
                    S_IDLE: if (grant) state <= S_ISSUE;
                    S_ISSUE: begin
                        cnt <= '0;
                        state <= S_RISE;
                    end
                    S_RISE:
                        if (tx_busy)
                            state <= S_FALL;
                        else if (cnt == CW'(BUSY_TIMEOUT - 1)) begin
                            timeout_err <= 1'b1;
                            cnt <= '0;
                            state <= S_GAP;
                        end else
                            cnt <= cnt + CW'(1);
                    S_FALL:
                        if (!tx_busy) begin
                            cnt <= '0;
                            state <= S_GAP;
                        end
                    S_GAP: state <= cnt == CW'(GAP_CYCLES - 1) ? S_IDLE : S_GAP;
                    default: state <= S_IDLE;
                endcase
            if (state == S_GAP && transmit)
                cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: doc/interboard_tx_scheduler.md
# interboard_tx_scheduler

Queues and arbitrates outbound messages from two producers (game control A, cursor/move updates B) onto the single `ctrl_en`/`ctrl_*` command port of the interboard link. Issues at most one message at a time, waits for the send engine's `tx_busy` to rise and fall, and enforces an inter-message gap. Sits between game control and the interboard communication top; only active while this board holds `transmit`.

## Interface
- `DEPTH`, 4: entries per producer FIFO (power of 2, ≥2)
- `A_STREAK_MAX`, 3: consecutive A grants before a pending B is forced
- `GAP_CYCLES`, 8: idle cycles after `tx_busy` falls before next issue
- `BUSY_TIMEOUT`, 255: cycles to wait for `tx_busy` to rise after issue
- `clk` in 1: system clock
- `rst` in 1: synchronous active-high reset
- `transmit` in 1: this board owns the link
- `interboard_rst` in 1: reset requested by other board; flushes like `rst`
- `tx_busy` in 1: send engine mid-transfer
- `a_en` / `b_en` in 1: push request, one cycle per message
- `a_msg` / `b_msg` in 22: `{move_dir, block_x[4:0], block_y[2:0], msg_type[3:0], card[5:0], sel_len[2:0]}`
- `a_full` / `b_full` out 1: FIFO count == DEPTH
- `b_overflow` out 1: one-cycle pulse, B push lost
- `timeout_err` out 1: sticky; set on busy timeout, cleared by reset
- `ctrl_en` out 1: one-cycle issue pulse
- `ctrl_move_dir` 1, `ctrl_block_x` 5, `ctrl_block_y` 3, `ctrl_msg_type` 4, `ctrl_card` 6, `ctrl_sel_len` 3: out, fields of issued message

## Operation
- Reset (`rst` or `interboard_rst`): FIFOs empty, FSM IDLE, streak = 0; all outputs 0.
- FIFO push: accepted if count < DEPTH or a pop of that FIFO occurs same cycle. A push to full A is ignored (producer must honor `a_full`).
- Arbitration in IDLE (only when `transmit`=1, gap expired): A non-empty and (B empty or streak < A_STREAK_MAX) → grant A, streak+1; else B non-empty → grant B, streak = 0. Grant pops the head and registers its fields.
- FSM:
  - IDLE → ISSUE on grant.
  - ISSUE: `ctrl_en`=1 for this cycle only → WAIT_RISE.
  - WAIT_RISE: `tx_busy`=1 → WAIT_FALL; counter reaches BUSY_TIMEOUT → set `timeout_err`, → GAP.
  - WAIT_FALL: `tx_busy`=0 → GAP.
  - GAP: count GAP_CYCLES → IDLE.
- `transmit` falling in any non-IDLE state: abort to IDLE on next edge, in-flight message discarded, FIFOs retained. While `transmit`=0 pushes still accepted, nothing issued.
- `ctrl_*` fields hold last issued value until next grant.

## Timing
- Empty system, IDLE, gap expired: push sampled at edge E0 → `ctrl_en` high in cycle after edge E1 (1-cycle latency from sample edge to issue).
- `tx_busy` sampled each cycle; earliest next `ctrl_en` = fall edge + GAP_CYCLES + 2.
- `tx_busy` already high in the ISSUE cycle counts on the following WAIT_RISE cycle.
- Simultaneous `a_en`, `b_en` and a grant pop: all three take effect same edge.
- `rst`/`interboard_rst` dominate every other event same edge.
- Streak counter saturates at A_STREAK_MAX; reset only on B grant or reset.

## Configuration
- `TX_SCHED_COALESCE_EN` defined: push to full B overwrites the newest B entry (latest cursor position wins); `b_overflow` pulses.
- Undefined: push to full B is dropped; `b_overflow` pulses; FIFO unchanged.

## Test plan
- Single A push (msg_type=4'h3, card=6'h12), `transmit`=1, `tx_busy` high 5 cycles → one `ctrl_en` pulse 1 cycle after push edge with those fields; next issue ≥ GAP_CYCLES after fall.
- 5 A + 2 B pushed back-to-back, default params → grant order A,A,A,B,A,A,B; no ctrl_en while `tx_busy`=1.
- `tx_busy` held 0 after issue → `timeout_err`=1 after 255 cycles, FSM proceeds to next entry.
- Fill B (4 entries), push 5th with block_x=5'd9 → `b_overflow` pulse; with `TX_SCHED_COALESCE_EN` 4th issued entry has block_x=9, without it the original 4th.
- `transmit` dropped in WAIT_FALL → IDLE, no `ctrl_en`; restored → remaining queue issued in order.
- `interboard_rst` with 3 queued entries → FIFOs empty, all outputs 0 next cycle, no further `ctrl_en`.
